// File: rtl/u409_pkg.sv
// Shared definitions for the U409 CIA bus-cycle logic: default E clock
// timing and the CIA cycle state encoding.
package u409_pkg;

    // E clock and cycle timing defaults in CLK40 cycles.
    localparam int E_LOW_DEF     = 34;
    localparam int E_HIGH_DEF    = 22;
    localparam int SETUP_MIN_DEF = 6;
    localparam int REL_TMO_DEF   = 12;

    // Width of the E phase counter (0..E_LOW+E_HIGH-1).
    localparam int E_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HOLD   = 3'd4
    } cia_state_e;

endpackage

// File: rtl/u409_eclk_gen.sv
// Free-running CIA E clock generator. E_CNT walks 0..E_LOW+E_HIGH-1;
// E is low for the first E_LOW counts and high for the rest. The rise and
// fall flags are true in the clock just before the registered E changes.
module u409_eclk_gen
    import u409_pkg::*;
#(
    parameter int E_LOW  = E_LOW_DEF,
    parameter int E_HIGH = E_HIGH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [E_CNT_W-1:0] e_cnt,
    output logic               clk_cia,
    output logic               e_rise,
    output logic               e_fall
);

    localparam logic [E_CNT_W-1:0] CNT_LAST = E_CNT_W'(E_LOW + E_HIGH - 1);
    localparam logic [E_CNT_W-1:0] CNT_RISE = E_CNT_W'(E_LOW - 1);
    localparam logic [E_CNT_W-1:0] CNT_HIGH = E_CNT_W'(E_LOW);

    logic [E_CNT_W-1:0] e_cnt_q;
    logic [E_CNT_W-1:0] e_cnt_d;
    logic               clk_cia_q;
    logic               clk_cia_d;

    // Next count wraps at the end of the period; E is derived from the next
    // count so the registered E lines up with the registered count.
    always_comb begin
        e_cnt_d   = (e_cnt_q == CNT_LAST) ? '0 : e_cnt_q + 1'b1;
        clk_cia_d = (e_cnt_d >= CNT_HIGH);
    end

    // Counter and E register; reset restarts the low phase from count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt_q   <= '0;
            clk_cia_q <= 1'b0;
        end else begin
            e_cnt_q   <= e_cnt_d;
            clk_cia_q <= clk_cia_d;
        end
    end

    assign e_cnt   = e_cnt_q;
    assign clk_cia = clk_cia_q;
    assign e_rise  = (e_cnt_q == CNT_RISE);
    assign e_fall  = (e_cnt_q == CNT_LAST);

endmodule

// File: rtl/u409_cia_cycle.sv
// CIA bus-cycle sequencer. Runs one 8520 access per CPU request decoded to
// the CIA window, stretching it so that chip selects and CIA_ENABLE cover a
// single full E-high phase.
//
// Handshake: a request is TSn low with CIA_SPACE high, accepted only in
// IDLE (all other TSn pulses are dropped); the cycle is complete when
// CIA_ENABLE falls, which happens after two consecutive TACKn-low samples
// in HOLD or after REL_TMO clocks without them.
module u409_cia_cycle
    import u409_pkg::*;
#(
    parameter int E_LOW     = E_LOW_DEF,
    parameter int E_HIGH    = E_HIGH_DEF,
    parameter int SETUP_MIN = SETUP_MIN_DEF,
    parameter int REL_TMO   = REL_TMO_DEF
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       TSn,
    input  logic       TACKn,
    input  logic       RWn,
    input  logic       CIA_SPACE,
    input  logic       A13,
    input  logic       A12,
    output logic       CLK_CIA,
    output logic       CIA_ENABLE,
    output logic       CIAACSn,
    output logic       CIABCSn,
    output logic       CIA_RLATCH,
    output logic       CIA_OEn,
    output cia_state_e STATE_DBG
);

    localparam int REL_W = $clog2(REL_TMO + 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_TMO);
    // Starting the cycle at a count below this leaves at least SETUP_MIN
    // clocks of select before E rises; it also implies E is low.
    localparam logic [E_CNT_W-1:0] SETUP_LIMIT = E_CNT_W'(E_LOW - SETUP_MIN);

    logic [E_CNT_W-1:0] e_cnt;
    logic               e_rise;
    logic               e_fall;

    cia_state_e         state_q, state_d;
    logic               rw_q, rw_d;
    logic               a13_q, a13_d;
    logic               a12_q, a12_d;
    logic               enable_q, enable_d;
    logic               acs_q, acs_d;
    logic               bcs_q, bcs_d;
    logic               rlatch_q, rlatch_d;
    logic               oen_q, oen_d;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic               tack_prev_q, tack_prev_d;

    u409_eclk_gen #(
        .E_LOW  (E_LOW),
        .E_HIGH (E_HIGH)
    ) u_eclk (
        .clk     (CLK40),
        .rst_n   (RESETn),
        .e_cnt   (e_cnt),
        .clk_cia (CLK_CIA),
        .e_rise  (e_rise),
        .e_fall  (e_fall)
    );

    // Cycle FSM: next state and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        a13_d       = a13_q;
        a12_d       = a12_q;
        enable_d    = enable_q;
        acs_d       = acs_q;
        bcs_d       = bcs_q;
        rlatch_d    = 1'b0;
        oen_d       = oen_q;
        rel_cnt_d   = rel_cnt_q;
        tack_prev_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!TSn && CIA_SPACE) begin
                    rw_d    = RWn;
                    a13_d   = A13;
                    a12_d   = A12;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // With neither address bit low no select fires; the release
                // timeout still closes the cycle.
                if (e_cnt < SETUP_LIMIT) begin
                    state_d  = ST_SETUP;
                    enable_d = 1'b1;
                    acs_d    = a12_q;
                    bcs_d    = a13_q;
                end
            end
            ST_SETUP: begin
                // Buffer enable switches on in the same clock E goes high.
                if (e_rise) begin
                    state_d = ST_ACTIVE;
                    oen_d   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (e_fall) begin
                    state_d   = ST_HOLD;
                    rlatch_d  = rw_q;
                    rel_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                // TACKn history is only tracked here, so an early ack
                // seen before HOLD cannot count toward release.
                tack_prev_d = !TACKn;
                if ((!TACKn && tack_prev_q) || (rel_cnt_q == REL_LAST)) begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                    acs_d    = 1'b1;
                    bcs_d    = 1'b1;
                    oen_d    = 1'b1;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, all cleared asynchronously on RESETn.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            a13_q       <= 1'b1;
            a12_q       <= 1'b1;
            enable_q    <= 1'b0;
            acs_q       <= 1'b1;
            bcs_q       <= 1'b1;
            rlatch_q    <= 1'b0;
            oen_q       <= 1'b1;
            rel_cnt_q   <= '0;
            tack_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            a13_q       <= a13_d;
            a12_q       <= a12_d;
            enable_q    <= enable_d;
            acs_q       <= acs_d;
            bcs_q       <= bcs_d;
            rlatch_q    <= rlatch_d;
            oen_q       <= oen_d;
            rel_cnt_q   <= rel_cnt_d;
            tack_prev_q <= tack_prev_d;
        end
    end

    assign CIA_ENABLE = enable_q;
    assign CIAACSn    = acs_q;
    assign CIABCSn    = bcs_q;
    assign CIA_RLATCH = rlatch_q;
    assign CIA_OEn    = oen_q;
    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_u409_cia_cycle.sv
// Bench for u409_cia_cycle: per-cycle E clock check against the elapsed
// clock count since reset release, and a transaction scoreboard whose
// expected records describe each CIA access by its timing and selects.
module tb_u409_cia_cycle;
    import u409_pkg::*;

    localparam int PERIOD      = E_LOW_DEF + E_HIGH_DEF;
    localparam int SETUP_LIMIT = E_LOW_DEF - SETUP_MIN_DEF;
    localparam int NO_TACK     = 1000;

    typedef struct packed {
        logic [31:0] start;
        logic [7:0]  setup;
        logic [7:0]  high;
        logic [7:0]  hold;
        logic [7:0]  oen;
        logic [7:0]  rlatch;
        logic [7:0]  stray;
        logic        acs;
        logic        bcs;
    } txn_t;
    localparam int W = $bits(txn_t);

    // ---------------- clock / reset ----------------
    logic       CLK40     = 1'b0;
    logic       RESETn    = 1'b0;
    logic       TSn       = 1'b1;
    logic       TACKn     = 1'b1;
    logic       RWn       = 1'b1;
    logic       CIA_SPACE = 1'b0;
    logic       A13       = 1'b1;
    logic       A12       = 1'b1;
    logic       CLK_CIA;
    logic       CIA_ENABLE;
    logic       CIAACSn;
    logic       CIABCSn;
    logic       CIA_RLATCH;
    logic       CIA_OEn;
    cia_state_e STATE_DBG;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int rel_cyc   = 0;
    int idle_viol = 0;

    logic [W-1:0] exp_q[$];

    always #5 CLK40 = ~CLK40;

    always @(posedge CLK40) cyc <= cyc + 1;

    u409_cia_cycle dut (
        .CLK40      (CLK40),
        .RESETn     (RESETn),
        .TSn        (TSn),
        .TACKn      (TACKn),
        .RWn        (RWn),
        .CIA_SPACE  (CIA_SPACE),
        .A13        (A13),
        .A12        (A12),
        .CLK_CIA    (CLK_CIA),
        .CIA_ENABLE (CIA_ENABLE),
        .CIAACSn    (CIAACSn),
        .CIABCSn    (CIABCSn),
        .CIA_RLATCH (CIA_RLATCH),
        .CIA_OEn    (CIA_OEn),
        .STATE_DBG  (STATE_DBG)
    );

    // ---------------- helpers ----------------
    function automatic int phase_now();
        return (cyc - rel_cyc) % PERIOD;
    endfunction

    function automatic string txn_str(input logic [W-1:0] v);
        txn_t t;
        t = txn_t'(v);
        return $sformatf("start=%0d setup=%0d high=%0d hold=%0d oen=%0d rlatch=%0d stray=%0d acs=%0b bcs=%0b",
                         t.start, t.setup, t.high, t.hold, t.oen, t.rlatch, t.stray, t.acs, t.bcs);
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_clk_cia"}, int'(CLK_CIA), 0);
        check_val({tag, "_enable"}, int'(CIA_ENABLE), 0);
        check_val({tag, "_acsn"}, int'(CIAACSn), 1);
        check_val({tag, "_bcsn"}, int'(CIABCSn), 1);
        check_val({tag, "_rlatch"}, int'(CIA_RLATCH), 0);
        check_val({tag, "_oen"}, int'(CIA_OEn), 1);
        check_val({tag, "_state"}, int'(STATE_DBG), int'(ST_IDLE));
    endtask

    // ---------------- driver tasks ----------------
    // Wait at negedges until the E phase equals p (p<0: issue now).
    task automatic wait_phase(input int p);
        int guard;
        guard = 0;
        while (p >= 0 && phase_now() != p && guard < 2 * PERIOD) begin
            @(negedge CLK40);
            guard++;
        end
    endtask

    // One CIA access. d: HOLD clock index at which TACKn goes low
    // (negative = before HOLD, NO_TACK = never). stray: clocks after the
    // request at which an extra TSn is issued mid-cycle (0 = none).
    task automatic do_txn(input int p, input bit rw, input bit a13, input bit a12,
                          input int d, input int stray);
        int   c, k, q, s, hold0, de, jrel, pn;
        txn_t e;
        wait_phase(p);
        c  = cyc;
        pn = phase_now();
        // The cycle may start at the first later phase that still leaves
        // SETUP_MIN low clocks before E rises; selects appear a clock after.
        k = 1;
        while (((pn + k) % PERIOD) >= SETUP_LIMIT) k++;
        q     = (pn + k) % PERIOD;
        s     = c + k + 1;
        hold0 = s + (E_LOW_DEF - 1 - q) + E_HIGH_DEF;
        de    = (d < 0) ? 0 : d;
        jrel  = (de + 1 < REL_TMO_DEF) ? de + 1 : REL_TMO_DEF;
        e        = '0;
        e.start  = 32'(s);
        e.setup  = 8'(E_LOW_DEF - 1 - q);
        e.high   = 8'(E_HIGH_DEF);
        e.hold   = 8'(jrel + 1);
        e.oen    = 8'(E_HIGH_DEF + jrel + 1);
        e.rlatch = rw ? 8'd1 : 8'd0;
        e.stray  = 8'd0;
        e.acs    = a12;
        e.bcs    = a13;
        exp_q.push_back(e);

        TSn = 1'b0; CIA_SPACE = 1'b1; RWn = rw; A13 = a13; A12 = a12;
        while (cyc < hold0 + jrel + 1) begin
            @(negedge CLK40);
            TSn       = 1'b1;
            CIA_SPACE = 1'($urandom_range(0, 1));
            RWn       = 1'($urandom_range(0, 1));
            A13       = 1'($urandom_range(0, 1));
            A12       = 1'($urandom_range(0, 1));
            if (stray != 0 && cyc == c + stray) TSn = 1'b0;
            if (d != NO_TACK && cyc == hold0 + d) TACKn = 1'b0;
        end
        TACKn = 1'b1;
    endtask

    // TSn outside the CIA window while idle must start nothing.
    task automatic ignored_ts();
        TSn = 1'b0; CIA_SPACE = 1'b0; RWn = 1'b1; A13 = 1'b0; A12 = 1'b0;
        @(negedge CLK40);
        TSn = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK40);
    endtask

    // ---------------- monitor / scoreboard ----------------
    txn_t act;
    bit   in_txn    = 1'b0;
    bit   seen_high = 1'b0;

    always @(negedge CLK40) begin
        if (!RESETn) begin
            in_txn = 1'b0;
        end else begin
            check_val("clk_cia_phase", int'(CLK_CIA), (phase_now() >= E_LOW_DEF) ? 1 : 0);
            if (CIA_ENABLE) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    seen_high = 1'b0;
                    act       = '0;
                    act.start = 32'(cyc);
                    act.acs   = CIAACSn;
                    act.bcs   = CIABCSn;
                end
                if (CIAACSn !== act.acs || CIABCSn !== act.bcs) act.stray = act.stray + 1'b1;
                if (CIA_RLATCH) begin
                    if (seen_high && !CLK_CIA && act.hold == 0) act.rlatch = act.rlatch + 1'b1;
                    else act.stray = act.stray + 1'b1;
                end
                if (CLK_CIA) begin
                    seen_high = 1'b1;
                    act.high  = act.high + 1'b1;
                end else if (!seen_high) begin
                    act.setup = act.setup + 1'b1;
                end else begin
                    act.hold = act.hold + 1'b1;
                end
                if (!CIA_OEn) begin
                    if (seen_high) act.oen = act.oen + 1'b1;
                    else act.stray = act.stray + 1'b1;
                end
            end else begin
                if (in_txn) begin
                    in_txn = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL txn_unexpected: got %s expected no cycle", txn_str(act));
                    end else begin
                        logic [W-1:0] ev;
                        ev = exp_q.pop_front();
                        if (W'(act) !== ev) begin
                            errors++;
                            $display("FAIL txn: got %s expected %s", txn_str(act), txn_str(ev));
                        end
                    end
                end
                if (!CIAACSn || !CIABCSn || !CIA_OEn || CIA_RLATCH) idle_viol++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p, d, stray, r;
        repeat (3) @(negedge CLK40);
        check_reset_outputs("por");
        RESETn  = 1'b1;
        rel_cyc = cyc;

        // Free-run with no accesses.
        idle_cycles(2 * PERIOD + 5);

        // Directed accesses.
        do_txn(2, 1'b1, 1'b1, 1'b0, 0, 0);            // read CIAA, ack 2 clocks
        idle_cycles(4);
        do_txn(30, 1'b1, 1'b1, 1'b0, 3, 10);          // late request + busy TSn
        idle_cycles(3);
        do_txn(10, 1'b0, 1'b0, 1'b1, 2, 0);           // write CIAB
        ignored_ts();
        do_txn(5, 1'b1, 1'b0, 1'b0, NO_TACK, 0);      // both selects, no ack
        do_txn(-1, 1'b1, 1'b1, 1'b0, 1, 0);           // accepted right after release
        idle_cycles(2);
        do_txn(55, 1'b0, 1'b1, 1'b1, NO_TACK, 0);     // capture at E fall, no CS
        do_txn(20, 1'b1, 1'b0, 1'b1, -3, 0);          // ack before HOLD
        do_txn(26, 1'b0, 1'b1, 1'b0, 5, 0);           // exactly SETUP_MIN clocks
        do_txn(27, 1'b1, 1'b0, 1'b1, 11, 0);          // one clock too late

        // Randomized accesses.
        for (int i = 0; i < 14; i++) begin
            p = $urandom_range(0, PERIOD - 1);
            r = $urandom_range(0, 9);
            d = (r == 0) ? NO_TACK : $urandom_range(0, 16) - 4;
            stray = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            do_txn(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), d, stray);
            if ($urandom_range(0, 2) == 0) ignored_ts();
            idle_cycles($urandom_range(0, 20));
        end

        // Reset in the middle of an access.
        wait_phase(2);
        TSn = 1'b0; CIA_SPACE = 1'b1; RWn = 1'b1; A13 = 1'b1; A12 = 1'b0;
        @(negedge CLK40);
        TSn = 1'b1;
        wait_phase(40);
        check_val("mid_enable", int'(CIA_ENABLE), 1);
        check_val("mid_state", int'(STATE_DBG), int'(ST_ACTIVE));
        #3 RESETn = 1'b0;
        #1 check_reset_outputs("async");
        repeat (3) @(negedge CLK40);
        RESETn  = 1'b1;
        rel_cyc = cyc;
        idle_cycles(PERIOD + 5);
        do_txn(3, 1'b1, 1'b1, 1'b0, 1, 0);            // normal access after reset
        idle_cycles(5);

        check_val("queue_empty", exp_q.size(), 0);
        check_val("idle_outputs", idle_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
